// File: rtl/register_bank.sv
// register_bank: NUM_REGS x WIDTH general registers sharing one store bus
// and one load bus. Any register can be stored, counted up in place with a
// registered wrap pulse, read back through a gated mux, and is always
// visible on the flattened COUNTER bus.
module register_bank #(
    parameter int              WIDTH     = 4,
    parameter int              NUM_REGS  = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      nST,
    input  logic [SEL_W-1:0]          ST_SEL,
    input  logic                      nOUT,
    input  logic [SEL_W-1:0]          OUT_SEL,
    input  logic                      INC,
    input  logic [SEL_W-1:0]          INC_SEL,
    input  logic [WIDTH-1:0]          STOREBUS,
    output logic [WIDTH-1:0]          LOADBUS,
    output logic [WIDTH*NUM_REGS-1:0] COUNTER,
    output logic                      CARRY
);

    // One extra bit so NUM_REGS itself is representable for the range compare.
    localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic                           st_ok;
    logic                           inc_ok;
    logic                           inc_eff;
    logic [WIDTH-1:0]               inc_cur;

    // Selects past the last register (non power-of-two banks) are dropped.
    assign st_ok  = !nST && ({1'b0, ST_SEL}  < LIMIT);
    assign inc_ok = INC  && ({1'b0, INC_SEL} < LIMIT);

    // A store to the same register overrides the increment entirely,
    // including its carry.
    assign inc_eff = inc_ok && !(st_ok && (ST_SEL == INC_SEL));

    // Current value of the register being incremented, for wrap detection.
    always_comb begin
        inc_cur = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (INC_SEL == SEL_W'(k)) inc_cur = regs[k];
        end
    end

    // Register array update: store has priority over increment per register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (st_ok && (ST_SEL == SEL_W'(k)))
                    regs[k] <= STOREBUS;
                else if (inc_eff && (INC_SEL == SEL_W'(k)))
                    regs[k] <= regs[k] + 1'b1;
            end
        end
    end

    // One-cycle carry pulse following an all-ones -> zero increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) CARRY <= 1'b0;
        else     CARRY <= inc_eff && (inc_cur == {WIDTH{1'b1}});
    end

    // Gated read mux; no bypass, so a same-cycle store shows after the edge.
    always_comb begin
        LOADBUS = '0;
        if (!nOUT) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (OUT_SEL == SEL_W'(k)) LOADBUS = regs[k];
            end
        end
    end

    // Packed array layout already places reg k at bits [k*WIDTH +: WIDTH].
    assign COUNTER = regs;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: a default 4x2 bank and a 8-bit
// three-register bank with a non-zero reset value, sharing clock and reset.
module tb_register_bank;

    logic clk = 1'b0;
    logic rst;

    // default instance: WIDTH=4, NUM_REGS=2
    logic       nst, nout, inc;
    logic       st_sel, out_sel, inc_sel;
    logic [3:0] storebus, loadbus;
    logic [7:0] counter;
    logic       carry;

    // second instance: WIDTH=8, NUM_REGS=3, RESET_VAL=8'h10
    logic        nst3, nout3, inc3;
    logic [1:0]  st_sel3, out_sel3, inc_sel3;
    logic [7:0]  storebus3, loadbus3;
    logic [23:0] counter3;
    logic        carry3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_bank dut (
        .CLK(clk), .RST(rst), .nST(nst), .ST_SEL(st_sel), .nOUT(nout),
        .OUT_SEL(out_sel), .INC(inc), .INC_SEL(inc_sel), .STOREBUS(storebus),
        .LOADBUS(loadbus), .COUNTER(counter), .CARRY(carry)
    );

    register_bank #(.WIDTH(8), .NUM_REGS(3), .RESET_VAL(8'h10)) dut3 (
        .CLK(clk), .RST(rst), .nST(nst3), .ST_SEL(st_sel3), .nOUT(nout3),
        .OUT_SEL(out_sel3), .INC(inc3), .INC_SEL(inc_sel3), .STOREBUS(storebus3),
        .LOADBUS(loadbus3), .COUNTER(counter3), .CARRY(carry3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance past the next rising edge, leaving 1 time unit of settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        nst = 1'b1; nout = 1'b1; inc = 1'b0;
        st_sel = 1'b0; out_sel = 1'b0; inc_sel = 1'b0; storebus = 4'h0;
        nst3 = 1'b1; nout3 = 1'b0; inc3 = 1'b0;
        st_sel3 = 2'd0; out_sel3 = 2'd1; inc_sel3 = 2'd0; storebus3 = 8'h00;

        // reset state
        #12;
        chk("rst_counter", 32'(counter), 32'h00);
        chk("rst_carry", 32'(carry), 32'h0);
        chk("rst_load_off", 32'(loadbus), 32'h0);
        chk("rst_counter3", 32'(counter3), 32'h101010);
        chk("rst_load3", 32'(loadbus3), 32'h10);
        chk("rst_carry3", 32'(carry3), 32'h0);
        rst = 1'b0;

        // store A into reg1; readback shows old value until the edge
        storebus = 4'hA; st_sel = 1'b1; nst = 1'b0;
        nout = 1'b0; out_sel = 1'b1;
        #1 chk("nobypass_old", 32'(loadbus), 32'h0);
        step();
        nst = 1'b1;
        chk("store_reg1", 32'(counter), 32'hA0);
        chk("load_reg1", 32'(loadbus), 32'hA);
        nout = 1'b1;
        #1 chk("load_disabled", 32'(loadbus), 32'h0);

        // store E into reg0, then increment 3 times: F, 0 (carry next), 1
        storebus = 4'hE; st_sel = 1'b0; nst = 1'b0;
        step();
        nst = 1'b1;
        chk("store_reg0_E", 32'(counter), 32'hAE);
        inc = 1'b1; inc_sel = 1'b0;
        step();
        chk("inc_F", 32'(counter), 32'hAF);
        chk("inc_F_carry", 32'(carry), 32'h0);
        step();
        chk("inc_wrap", 32'(counter), 32'hA0);
        chk("inc_wrap_carry", 32'(carry), 32'h1);
        step();
        chk("inc_1", 32'(counter), 32'hA1);
        chk("inc_1_carry", 32'(carry), 32'h0);
        inc = 1'b0;

        // reg0=F, then store 5 and increment reg0 together: store wins
        storebus = 4'hF; nst = 1'b0; st_sel = 1'b0;
        step();
        storebus = 4'h5; inc = 1'b1; inc_sel = 1'b0;
        step();
        chk("st_inc_same", 32'(counter), 32'hA5);
        chk("st_inc_same_carry", 32'(carry), 32'h0);
        // store reg0 and increment reg1 together: both apply
        storebus = 4'h5; inc_sel = 1'b1;
        step();
        nst = 1'b1; inc = 1'b0;
        chk("st_inc_diff", 32'(counter), 32'hB5);

        // wrap reg1 for a carry, then async reset clears carry at once
        storebus = 4'hF; st_sel = 1'b1; nst = 1'b0;
        step();
        nst = 1'b1; inc = 1'b1; inc_sel = 1'b1;
        step();
        inc = 1'b0;
        chk("wrap_reg1", 32'(counter), 32'h05);
        chk("wrap_reg1_carry", 32'(carry), 32'h1);
        #2 rst = 1'b1;
        #1 chk("async_carry_clr", 32'(carry), 32'h0);
        rst = 1'b0;

        // regs 3/7, then a mid-cycle reset with a store held across it
        storebus = 4'h3; st_sel = 1'b0; nst = 1'b0;
        step();
        storebus = 4'h7; st_sel = 1'b1;
        step();
        chk("pre_rst", 32'(counter), 32'h73);
        storebus = 4'h9;
        #2 rst = 1'b1;
        #1 chk("async_rst_now", 32'(counter), 32'h00);
        step();
        chk("rst_held_edge", 32'(counter), 32'h00);
        #2 rst = 1'b0;
        step();
        chk("store_after_rel", 32'(counter), 32'h90);
        nst = 1'b1;

        // 3-register bank: out-of-range selects are ignored
        chk("rst3_again", 32'(counter3), 32'h101010);
        nst3 = 1'b0; st_sel3 = 2'd3; storebus3 = 8'hFF;
        step();
        nst3 = 1'b1;
        chk("oor_store3", 32'(counter3), 32'h101010);
        inc3 = 1'b1; inc_sel3 = 2'd3;
        step();
        inc3 = 1'b0;
        chk("oor_inc3", 32'(counter3), 32'h101010);
        chk("oor_inc3_carry", 32'(carry3), 32'h0);
        nout3 = 1'b0; out_sel3 = 2'd3;
        #1 chk("oor_load3", 32'(loadbus3), 32'h00);
        nst3 = 1'b0; st_sel3 = 2'd2; storebus3 = 8'hAB;
        step();
        nst3 = 1'b1;
        chk("store3_reg2", 32'(counter3), 32'hAB1010);
        out_sel3 = 2'd2;
        #1 chk("load3_reg2", 32'(loadbus3), 32'hAB);
        // out-of-range store alongside a valid increment: only the increment
        nst3 = 1'b0; st_sel3 = 2'd3; storebus3 = 8'h55;
        inc3 = 1'b1; inc_sel3 = 2'd0;
        step();
        chk("oor_st_inc3", 32'(counter3), 32'hAB1011);
        step();
        nst3 = 1'b1; inc3 = 1'b0;
        chk("inc3_held", 32'(counter3), 32'hAB1012);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised successor to the single 4-bit A/B registers of the TTM4 emulator: a bank of NUM_REGS general registers, each WIDTH bits, sharing one store bus and one load bus. Each register stores from STOREBUS under an active-low strobe and can also count up in place with a registered carry pulse, so the same bank serves as the A/B registers and the program counter. All register contents are also exported on a flattened COUNTER bus for display and debug.

## Interface
- WIDTH, 4: bits per register.
- NUM_REGS, 2: number of registers (≥1).
- RESET_VAL, 0: value loaded into every register on reset (WIDTH bits).
- SEL_W, derived: max(1, clog2(NUM_REGS)); not overridable.

- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- nST  in  1  active-low store strobe.
- ST_SEL  in  SEL_W  register written when nST=0.
- nOUT  in  1  active-low output enable for LOADBUS.
- OUT_SEL  in  SEL_W  register driven onto LOADBUS.
- INC  in  1  active-high increment request.
- INC_SEL  in  SEL_W  register incremented when INC=1.
- STOREBUS  in  WIDTH  write data.
- LOADBUS  out  WIDTH  selected register contents, or 0.
- COUNTER  out  WIDTH*NUM_REGS  all registers, reg k at bits [k*WIDTH +: WIDTH].
- CARRY  out  1  registered one-cycle pulse on increment wrap.

## Operation
- Reset (RST=1, asynchronous): every register = RESET_VAL, CARRY = 0; held while RST=1, inputs ignored.
- Store: nST=0 at a rising edge with ST_SEL < NUM_REGS -> reg[ST_SEL] <= STOREBUS.
- Increment: INC=1 at a rising edge with INC_SEL < NUM_REGS -> reg[INC_SEL] <= reg[INC_SEL] + 1, modulo 2^WIDTH.
- CARRY <= 1 for exactly the cycle following an increment that wraps all-ones to 0; else CARRY <= 0.
- Store and increment to the same register in one cycle: store wins, no increment, CARRY <= 0.
- Store and increment to different registers in one cycle: both take effect.
- Out-of-range ST_SEL or INC_SEL (NUM_REGS not a power of two): operation ignored, no register changes, CARRY <= 0.
- LOADBUS (combinational): nOUT=0 and OUT_SEL < NUM_REGS -> reg[OUT_SEL]; otherwise all zeros. No tri-state inside the block.
- COUNTER (combinational): direct concatenation of current register values.

## Timing
- Store and increment latency: 1 cycle; the new value is visible on COUNTER/LOADBUS after the edge.
- LOADBUS reading a register written in the same cycle shows the old value until the edge; there is no bypass.
- CARRY is asserted in the cycle after the wrapping edge, for exactly one cycle. Back-to-back wrapping increments are impossible for WIDTH≥2. For WIDTH=1, CARRY toggles as each wrap occurs.
- RST asserted mid-operation: registers and CARRY clear immediately without waiting for CLK. The first edge after release applies the inputs present at that edge.
- Strobes are level-sampled at each rising edge. Holding nST=0 for N cycles rewrites STOREBUS N times. Holding INC=1 for N cycles increments N times.
- Reset outputs: LOADBUS = 0 when nOUT=1, else RESET_VAL; COUNTER = RESET_VAL replicated; CARRY = 0.

## Test plan
- Default params (WIDTH=4, NUM_REGS=2). Reset, then STOREBUS=4'b1010, ST_SEL=1, nST low for 1 cycle -> COUNTER=8'hA0, reg0 unchanged. nOUT=0, OUT_SEL=1 -> LOADBUS=4'hA. nOUT=1 -> LOADBUS=0.
- Store 4'hE into reg0, then INC=1, INC_SEL=0 for 3 cycles -> reg0 reads F, 0, 1. CARRY=1 only in the cycle after the F->0 edge.
- Same cycle: nST=0, ST_SEL=0, STOREBUS=4'h5 and INC=1, INC_SEL=0 with reg0=4'hF -> reg0=5, CARRY stays 0. Repeat with INC_SEL=1 -> reg0=5, reg1 incremented.
- Pulse RST mid-sequence, between clock edges, with regs 4'h3/4'h7 -> COUNTER=0 immediately. A held nST=0 takes effect at the first edge after release.
- NUM_REGS=3, WIDTH=8, RESET_VAL=8'h10: after reset, COUNTER=24'h101010. A store or increment with select=3 changes nothing. OUT_SEL=3 with nOUT=0 -> LOADBUS=0.
- Readback without bypass: in the write cycle, LOADBUS shows the old value; in the next cycle it shows the new value.
